// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller: opcodes, FSM states,
// datapath select codes and trap causes.
package riscv_mc_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [4:0] {
        S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_AUIPC, S_WB_ALU,
        S_EX_ADDR, S_MEM_LD, S_WB_LD, S_MEM_ST, S_EX_B, S_EX_J,
        S_JAL_WB, S_JAL_PC, S_EX_JALR, S_JALR_PC, S_WB_U, S_TRAP
    } state_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; flags a timeout in the cycle the stall count
// reaches MEM_TIMEOUT without memReady. MEM_TIMEOUT=0 never times out.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic waiting,
    input  logic memReady,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || memReady)
            cnt_d = '0;
        else if (waiting)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // cnt_q holds completed stall cycles, so this cycle is stall number LIMIT+1
    assign timeout = (MEM_TIMEOUT != 0) && waiting && !memReady && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_main_controller_hs.sv
// Main-control FSM for the multi-cycle RV32I core with req/ready memory handshake,
// memory timeout, sticky trap and retired-instruction counter.
module mc_main_controller_hs
    import riscv_mc_pkg::*;
#(
    parameter int INSTRET_W   = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int EN_AUIPC    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic                 memReady,
    output logic                 memReq,
    output logic                 adrSrc,
    output logic                 memWrite,
    output logic                 IRWrite,
    output logic                 PCUpdate,
    output logic                 regWrite,
    output logic                 branch,
    output logic [2:0]           immSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           resultSrc,
    output logic                 trap,
    output logic [1:0]           trapCause,
    output logic [INSTRET_W-1:0] instret
);

    state_e               state_q, state_d;
    logic [1:0]           cause_q, cause_d;
    logic                 trap_q;
    logic [INSTRET_W-1:0] instret_q;
    logic                 mem_wait, timeout, retire;

    // Kept separate from memReq so the timer input does not loop through the FSM block
    assign mem_wait = rst && (state_q == S_FETCH || state_q == S_MEM_LD || state_q == S_MEM_ST);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (!mem_wait),
        .waiting  (mem_wait),
        .memReady (memReady),
        .timeout  (timeout)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        memReq    = 1'b0;
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCUpdate  = 1'b0;
        regWrite  = 1'b0;
        branch    = 1'b0;
        immSrc    = IMM_I;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALU_ADD;
        resultSrc = RES_ALUOUT;

        case (state_q)
            S_FETCH: begin
                memReq    = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                resultSrc = RES_ALU;
                IRWrite   = memReady;
                PCUpdate  = memReady;
                if (memReady) state_d = S_DECODE;
                else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                immSrc  = IMM_B;
                case (op)
                    OP_R:         state_d = S_EX_R;
                    OP_I:         state_d = S_EX_I;
                    OP_LD, OP_ST: state_d = S_EX_ADDR;
                    OP_B:         state_d = S_EX_B;
                    OP_JAL:       state_d = S_EX_J;
                    OP_JALR:      state_d = S_EX_JALR;
                    OP_LUI:       state_d = S_WB_U;
                    OP_AUIPC: begin
                        if (EN_AUIPC != 0) state_d = S_EX_AUIPC;
                        else begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EX_R: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALU_R;
                state_d = S_WB_ALU;
            end
            S_EX_I: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_I;
                state_d = S_WB_ALU;
            end
            S_EX_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                immSrc  = IMM_U;
                state_d = S_WB_ALU;
            end
            S_WB_ALU: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EX_ADDR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                immSrc  = (op == OP_LD) ? IMM_I : IMM_S;
                state_d = (op == OP_LD) ? S_MEM_LD : S_MEM_ST;
            end
            S_MEM_LD: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
                if (memReady) state_d = S_WB_LD;
                else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB_LD: begin
                resultSrc = RES_MEM;
                regWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ST: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                adrSrc   = 1'b1;
                if (memReady) state_d = S_FETCH;
                else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_EX_B: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALU_BR;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_EX_J: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                state_d = S_JAL_WB;
            end
            S_JAL_WB: begin
                regWrite = 1'b1;
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_IMM;
                immSrc   = IMM_J;
                state_d  = S_JAL_PC;
            end
            S_JAL_PC: begin
                PCUpdate = 1'b1;
                state_d  = S_FETCH;
            end
            S_EX_JALR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JALR_PC;
            end
            S_JALR_PC: begin
                PCUpdate = 1'b1;
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                state_d  = S_WB_ALU;
            end
            S_WB_U: begin
                resultSrc = RES_IMM;
                immSrc    = IMM_U;
                regWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: ;
            default: state_d = S_FETCH;
        endcase

        if (!rst) begin
            memReq    = 1'b0;
            adrSrc    = 1'b0;
            memWrite  = 1'b0;
            IRWrite   = 1'b0;
            PCUpdate  = 1'b0;
            regWrite  = 1'b0;
            branch    = 1'b0;
            immSrc    = IMM_I;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_RS2;
            ALUOp     = ALU_ADD;
            resultSrc = RES_ALUOUT;
        end
    end

    // TRAP never returns to FETCH, so only genuine completions count
    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            cause_q   <= CAUSE_NONE;
            trap_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            trap_q  <= (state_d == S_TRAP);
            if (retire) instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign trap      = trap_q;
    assign trapCause = cause_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_mc_main_controller_hs.sv
// Bench for mc_main_controller_hs: instruction-level model expands each instruction
// into its expected per-cycle control words, checked every cycle at negedge.
module tb_mc_main_controller_hs;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam int TO = 4;

    typedef enum int {
        P_FETCH, P_DECODE, P_EXR, P_EXI, P_AUI, P_WBALU, P_EXLD, P_EXST, P_MEMLD, P_WBLD,
        P_MEMST, P_EXB, P_EXJ, P_JALWB, P_JALPC, P_EXJALR, P_JALRPC, P_WBU, P_TRAP, P_RST
    } ph_e;

    typedef struct packed {
        logic memReq, adrSrc, memWrite, IRWrite, PCUpdate, regWrite, branch;
        logic [2:0] imm;
        logic [1:0] a, b, alu, res;
    } ctl_t;

    typedef struct {
        ph_e        ph;
        ctl_t       c;
        bit         chk_st;
        logic [6:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst, memReady;
    logic [6:0] op;
    logic memReq, adrSrc, memWrite, IRWrite, PCUpdate, regWrite, branch, trap;
    logic [2:0] immSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, resultSrc, trapCause;
    logic [3:0] instret;

    logic rst2, rdy2;
    logic [6:0] op2;
    logic memReq2, adrSrc2, memWrite2, IRWrite2, PCUpdate2, regWrite2, branch2, trap2;
    logic [2:0] immSrc2;
    logic [1:0] ALUSrcA2, ALUSrcB2, ALUOp2, resultSrc2, trapCause2;
    logic [31:0] instret2;

    always #5 clk = ~clk;

    mc_main_controller_hs #(.INSTRET_W(4), .MEM_TIMEOUT(TO), .EN_AUIPC(1)) u_dut (
        .clk(clk), .rst(rst), .op(op), .memReady(memReady), .memReq(memReq), .adrSrc(adrSrc),
        .memWrite(memWrite), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .regWrite(regWrite),
        .branch(branch), .immSrc(immSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .resultSrc(resultSrc), .trap(trap), .trapCause(trapCause), .instret(instret)
    );

    mc_main_controller_hs #(.INSTRET_W(32), .MEM_TIMEOUT(0), .EN_AUIPC(0)) u_dut2 (
        .clk(clk), .rst(rst2), .op(op2), .memReady(rdy2), .memReq(memReq2), .adrSrc(adrSrc2),
        .memWrite(memWrite2), .IRWrite(IRWrite2), .PCUpdate(PCUpdate2), .regWrite(regWrite2),
        .branch(branch2), .immSrc(immSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2),
        .resultSrc(resultSrc2), .trap(trap2), .trapCause(trapCause2), .instret(instret2)
    );

    int n_chk = 0, n_err = 0;
    exp_t exp_q[$];
    logic [3:0] exp_inst = 4'd0;
    logic [1:0] exp_cause = 2'd0;

    // Control word each phase must present, straight from the datapath contract
    function automatic ctl_t word(ph_e ph, bit rdy);
        ctl_t c = '0;
        case (ph)
            P_FETCH:  begin c.memReq = 1; c.b = 2; c.res = 2; c.IRWrite = rdy; c.PCUpdate = rdy; end
            P_DECODE: begin c.a = 1; c.b = 1; c.imm = 3'b010; end
            P_EXR:    begin c.a = 2; c.alu = 2; end
            P_EXI:    begin c.a = 2; c.b = 1; c.alu = 3; end
            P_AUI:    begin c.a = 1; c.b = 1; c.imm = 3'b100; end
            P_WBALU:  c.regWrite = 1;
            P_EXLD:   begin c.a = 2; c.b = 1; end
            P_EXST:   begin c.a = 2; c.b = 1; c.imm = 3'b001; end
            P_MEMLD:  begin c.memReq = 1; c.adrSrc = 1; end
            P_WBLD:   begin c.res = 1; c.regWrite = 1; end
            P_MEMST:  begin c.memReq = 1; c.adrSrc = 1; c.memWrite = 1; end
            P_EXB:    begin c.a = 2; c.alu = 1; c.branch = 1; end
            P_EXJ:    begin c.a = 1; c.b = 2; end
            P_JALWB:  begin c.regWrite = 1; c.a = 1; c.b = 1; c.imm = 3'b011; end
            P_JALPC:  c.PCUpdate = 1;
            P_EXJALR: begin c.a = 2; c.b = 1; end
            P_JALRPC: begin c.PCUpdate = 1; c.a = 1; c.b = 2; end
            P_WBU:    begin c.res = 3; c.imm = 3'b100; c.regWrite = 1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    task automatic step(input ph_e ph, input bit rdy);
        exp_t e;
        memReady = rdy;
        e.ph = ph;
        e.c = word(ph, rdy);
        e.chk_st = (ph != P_RST);
        e.st = {ph == P_TRAP, (ph == P_TRAP) ? exp_cause : 2'd0, exp_inst};
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (ph == P_RST) exp_inst = 4'd0;
    endtask

    // Stall mw cycles then complete, unless the stall budget runs out first
    task automatic mem_phase(input ph_e ph, input int mw, output bit tr);
        tr = 0;
        for (int k = 0; k <= mw; k++) begin
            if (TO != 0 && k == TO) begin
                tr = 1;
                exp_cause = 2'd2;
                return;
            end
            step(ph, k == mw);
        end
    endtask

    task automatic instr(input logic [6:0] o, input int fw, input int mw);
        bit tr;
        op = o;
        mem_phase(P_FETCH, fw, tr);
        if (tr) return;
        step(P_DECODE, 1);
        case (o)
            OP_R:     begin step(P_EXR, 1); step(P_WBALU, 0); end
            OP_I:     begin step(P_EXI, 1); step(P_WBALU, 1); end
            OP_AUIPC: begin step(P_AUI, 1); step(P_WBALU, 1); end
            OP_LD: begin
                step(P_EXLD, 1);
                mem_phase(P_MEMLD, mw, tr);
                if (tr) return;
                step(P_WBLD, 1);
            end
            OP_ST: begin
                step(P_EXST, 1);
                mem_phase(P_MEMST, mw, tr);
                if (tr) return;
            end
            OP_B:    step(P_EXB, 1);
            OP_JAL:  begin step(P_EXJ, 1); step(P_JALWB, 1); step(P_JALPC, 1); end
            OP_JALR: begin step(P_EXJALR, 1); step(P_JALRPC, 1); step(P_WBALU, 1); end
            OP_LUI:  step(P_WBU, 1);
            default: begin exp_cause = 2'd1; step(P_TRAP, 1); return; end
        endcase
        exp_inst = exp_inst + 4'd1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(P_RST, 1);
        rst = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin : cmp
            exp_t e;
            ctl_t g;
            logic [6:0] gs;
            e = exp_q.pop_front();
            g = {memReq, adrSrc, memWrite, IRWrite, PCUpdate, regWrite, branch,
                 immSrc, ALUSrcA, ALUSrcB, ALUOp, resultSrc};
            gs = {trap, trapCause, instret};
            n_chk++;
            if (g !== e.c) begin
                n_err++;
                $display("FAIL ctl t=%0t ph=%s got=%h exp=%h", $time, e.ph.name(), g, e.c);
            end
            if (e.chk_st) begin
                n_chk++;
                if (gs !== e.st) begin
                    n_err++;
                    $display("FAIL status t=%0t ph=%s got=%h exp=%h", $time, e.ph.name(), gs, e.st);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; memReady = 1'b0; op = 7'd0;
        rst2 = 1'b0; rdy2 = 1'b0; op2 = 7'd0;
        @(posedge clk); #1;
        step(P_RST, 1);
        do_reset();

        instr(OP_I, 0, 0);
        chk("addi_instret", 32'(instret), 32'd1);
        instr(OP_LD, 2, 3);
        instr(OP_ST, 0, 3);
        chk("sw_late_ready_no_trap", {30'd0, trap, 1'b0}, 32'd0);
        instr(OP_R, 1, 0);
        instr(OP_B, 0, 0);
        instr(OP_LUI, 0, 0);
        instr(OP_AUIPC, 0, 0);
        instr(OP_JAL, 0, 0);
        instr(OP_JALR, 0, 0);
        chk("instret_after_jal_jalr", 32'(instret), 32'd9);

        // Abandon a load mid-stall
        op = OP_LD;
        step(P_FETCH, 1); step(P_DECODE, 1); step(P_EXLD, 1);
        step(P_MEMLD, 0); step(P_MEMLD, 0);
        do_reset();
        chk("instret_after_reset", 32'(instret), 32'd0);
        instr(OP_I, 0, 0);

        instr(OP_ST, 0, 10);
        for (int i = 0; i < 3; i++) step(P_TRAP, i[0]);
        chk("timeout_trap", {30'd0, trap, memReq}, 32'd2);
        chk("timeout_cause", 32'(trapCause), 32'd2);
        do_reset();
        chk("trap_cleared", {30'd0, trap, 1'b0}, 32'd0);

        instr(7'b0001111, 0, 0);
        step(P_TRAP, 1); step(P_TRAP, 0);
        chk("illegal_cause", 32'(trapCause), 32'd1);
        chk("illegal_instret", 32'(instret), 32'd0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: instr(OP_I, 0, 0);
                1: instr(OP_R, 0, 0);
                2: instr(OP_LUI, 0, 0);
                default: instr(OP_B, 0, 0);
            endcase
            if (i == 14) chk("instret_15", 32'(instret), 32'd15);
        end
        chk("instret_wrap", 32'(instret), 32'd0);

        // Second controller: AUIPC disabled, timeout disabled
        rst2 = 1'b1; rdy2 = 1'b1; op2 = OP_AUIPC;
        repeat (3) @(posedge clk);
        #1;
        chk("auipc_dis_trap", {31'd0, trap2}, 32'd1);
        chk("auipc_dis_cause", 32'(trapCause2), 32'd1);
        chk("auipc_dis_memReq", {31'd0, memReq2}, 32'd0);
        rst2 = 1'b0;
        @(posedge clk); #1;
        rst2 = 1'b1; op2 = OP_LD;
        repeat (3) @(posedge clk);
        #1;
        rdy2 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_timeout_hold", {29'd0, trap2, memReq2, adrSrc2}, 32'd3);
        rdy2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("no_timeout_retire", instret2, 32'd1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
